// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard forwarding, load-use stall, branch flush and interrupt drain control
module pipeline_hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int EX_STAGES = 2,
  parameter int BRANCH_PENALTY = 2,
  localparam int SELW = $clog2(EX_STAGES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dec_valid,
  input  logic [ADDR_W-1:0] i_dec_a_addr,
  input  logic [ADDR_W-1:0] i_dec_b_addr,
  input  logic              i_dec_a_read,
  input  logic              i_dec_b_read,
  input  logic              i_dec_wr_en,
  input  logic [ADDR_W-1:0] i_dec_wr_addr,
  input  logic              i_dec_is_load,
  input  logic              i_br_resolve,
  input  logic              i_br_taken,
  input  logic              i_interrupt,
  input  logic              i_int_en,
  output logic              o_fetch_stall,
  output logic              o_dec_nop,
  output logic [SELW-1:0]   o_fwd_a_sel,
  output logic [SELW-1:0]   o_fwd_b_sel,
  output logic              o_pc_load,
  output logic              o_pc_mux_override,
  output logic              o_int_ack,
  output logic              o_sb_empty
);
  typedef enum logic [1:0] {IDLE, DRAIN, VECTOR} state_t;
  state_t            r_st, w_st_nxt;
  logic [EX_STAGES:1] r_v, r_l;
  logic [ADDR_W-1:0] r_a [1:EX_STAGES];
  logic [2:0]        r_fc;
  logic [SELW:0]     w_la, w_lb;
  logic              w_use_a, w_use_b, w_haz, w_vec, w_drain, w_flush, w_br, w_taken;
  // {hazard, select} of the youngest valid entry writing addr; loop runs old-to-young so the youngest wins
  function automatic logic [SELW:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [SELW:0] res;
    res = '0;
    for (int k = EX_STAGES; k >= 1; k--)
      if (r_v[k] && r_a[k] == addr)
        res = (!r_l[k] || k == EX_STAGES) ? {1'b0, SELW'(k)} : {1'b1, {SELW{1'b0}}};
    return res;
  endfunction
  always_comb begin
    w_la = lookup(i_dec_a_addr);
    w_lb = lookup(i_dec_b_addr);
    w_use_a = i_dec_valid & i_dec_a_read;
    w_use_b = i_dec_valid & i_dec_b_read;
    o_fwd_a_sel = w_use_a ? w_la[SELW-1:0] : '0;
    o_fwd_b_sel = w_use_b ? w_lb[SELW-1:0] : '0;
    w_haz = (w_use_a & w_la[SELW]) | (w_use_b & w_lb[SELW]);
    w_vec = r_st == VECTOR;
    w_drain = r_st == DRAIN;
    w_flush = |r_fc;
    w_br = i_br_resolve & i_br_taken;
    w_taken = w_br & ~w_vec;
    o_pc_load = i_rst_n & (w_vec | w_br);
    o_pc_mux_override = w_vec;
    o_int_ack = w_vec;
    o_dec_nop = ~i_rst_n | w_vec | w_drain | w_flush | (w_haz & ~w_taken);
    o_fetch_stall = i_rst_n & ~w_vec & ~w_taken & ~w_flush & (w_drain | w_haz);
    o_sb_empty = ~|r_v;
    w_st_nxt = r_st == IDLE ? ((i_interrupt & i_int_en & ~w_flush) ? DRAIN : IDLE) :
               w_drain ? (o_sb_empty ? VECTOR : DRAIN) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st <= IDLE;
      r_fc <= '0;
      r_v <= '0;
      r_l <= '0;
      for (int k = 1; k <= EX_STAGES; k++) r_a[k] <= '0;
    end else begin
      r_st <= w_st_nxt;
      r_fc <= w_taken ? 3'(BRANCH_PENALTY) : w_flush ? r_fc - 3'd1 : r_fc;
      for (int k = EX_STAGES; k > 1; k--) begin
        r_v[k] <= r_v[k-1];
        r_l[k] <= r_l[k-1];
        r_a[k] <= r_a[k-1];
      end
      r_v[1] <= i_dec_valid & i_dec_wr_en & ~o_dec_nop;
      r_l[1] <= i_dec_is_load;
      r_a[1] <= i_dec_wr_addr;
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, register-file address width.
REQ-002 Parameter EX_STAGES, default 2, in-flight stages between decode and writeback (legal 1..4).
REQ-003 Parameter BRANCH_PENALTY, default 2, bubble cycles inserted after a taken branch (legal 1..7).
REQ-004 Derived SELW = $clog2(EX_STAGES+1), forwarding-select width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 dec_valid  in  1  decode stage holds a real instruction.
REQ-008 dec_a_addr, dec_b_addr  in  ADDR_W each  source operand addresses.
REQ-009 dec_a_read, dec_b_read  in  1 each  operand actually read.
REQ-010 dec_wr_en  in  1  instruction writes the register file.
REQ-011 dec_wr_addr  in  ADDR_W  destination address.
REQ-012 dec_is_load  in  1  result valid only at final stage (scratch/stack/port read).
REQ-013 br_resolve  in  1  execute stage resolves a branch this cycle.
REQ-014 br_taken  in  1  qualified by br_resolve.
REQ-015 interrupt  in  1  level request; int_en  in  1  interrupt enable flag.
REQ-016 fetch_stall  out  1  hold PC and fetch register.
REQ-017 dec_nop  out  1  replace decoded control vector with a bubble.
REQ-018 fwd_a_sel, fwd_b_sel  out  SELW each  0 = register file, k = stage k result.
REQ-019 pc_load  out  1; pc_mux_override  out  1  force interrupt vector; int_ack  out  1.
REQ-020 sb_empty  out  1  no valid scoreboard entries.

Function
REQ-021 Scoreboard: EX_STAGES entries {valid, addr, is_load}; shifts stage k to k+1 each cycle; stage EX_STAGES entry retires.
REQ-022 Stage 1 loads {dec_valid & dec_wr_en & ~dec_nop, dec_wr_addr, dec_is_load}; when dec_nop=1 a bubble (valid=0) enters.
REQ-023 Entry at stage k is ready when is_load=0, or when k = EX_STAGES.
REQ-024 Forwarding: fwd_x_sel = lowest k whose valid entry matches dec_x_addr and is ready, else 0; youngest match wins.
REQ-025 Load-use hazard: youngest matching valid entry not ready and dec_x_read=1 -> fetch_stall=1, dec_nop=1 that cycle.
REQ-026 Unread operands (dec_x_read=0) never cause a stall; fwd_x_sel=0.
REQ-027 Taken branch (br_resolve & br_taken): pc_load=1 same cycle; flush counter loads BRANCH_PENALTY; dec_nop=1 while counter != 0; counter decrements per cycle.
REQ-028 Flush overrides load-use stall: fetch_stall=0 during flush cycles.
REQ-029 Not-taken branch: no action.
REQ-030 Interrupt FSM states IDLE, DRAIN, VECTOR.
REQ-031 IDLE -> DRAIN when interrupt & int_en & flush counter = 0; else stays IDLE.
REQ-032 DRAIN: fetch_stall=1, dec_nop=1; -> VECTOR when sb_empty=1.
REQ-033 VECTOR: one cycle, pc_load=1, pc_mux_override=1, int_ack=1, dec_nop=1; -> IDLE.
REQ-034 Priority per cycle: VECTOR > taken branch > DRAIN > load-use stall.
REQ-035 Taken branch during DRAIN: pc_load=1, flush counter loads, FSM stays DRAIN.
REQ-036 interrupt deasserted during DRAIN: FSM still completes to VECTOR (request latched).
REQ-037 Outputs combinational from state and inputs; no output depends on dec_* when dec_valid=0 except fwd sels = 0.

Reset
REQ-038 rst=0 asynchronously clears scoreboard, flush counter, FSM to IDLE.
REQ-039 During reset: fetch_stall=0, dec_nop=1, fwd sels=0, pc_load=0, pc_mux_override=0, int_ack=0, sb_empty=1.
REQ-040 Reset mid-DRAIN or mid-flush abandons the sequence; no int_ack issued.

Verification (EX_STAGES=2, BRANCH_PENALTY=2)
REQ-041 ALU write r3, next instr reads A=r3 -> fwd_a_sel=1, no stall; one cycle later reader -> fwd_a_sel=2.
REQ-042 Load r5, next reads B=r5 -> fetch_stall=1, dec_nop=1 for 1 cycle, then fwd_b_sel=2.
REQ-043 Two writers r7 in stages 1 and 2, reader r7 -> fwd_a_sel=1.
REQ-044 br_resolve=1, br_taken=1 coincident with load-use hazard -> pc_load=1, fetch_stall=0, dec_nop=1 for exactly 2 cycles.
REQ-045 interrupt=1, int_en=1, two valid entries -> DRAIN 2 cycles, then single-cycle int_ack with pc_mux_override=1; int_en=0 -> no response.
REQ-046 rst=0 asserted mid-DRAIN -> sb_empty=1, FSM IDLE immediately, int_ack never pulses.
